code_entry_ctrl: RTL and testbench

//  Sequential front-end that drives the combinational code checker (ass1). Accepts

---
 rtl/code_entry_ctrl.sv | 163 ++++++++++++++++
 tb/tb_code_entry_ctrl.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_entry_ctrl.sv
// code_entry_ctrl
//   Sequential front-end for the combinational code checker. A keyed 4-bit code
//   is registered onto CODE and held for a settle window. The checker's
//   OPEN/CORR1/CORR2 are then sampled in a single evaluation cycle. A pass opens
//   UNLOCK for a timed window. A failure pulses FAIL and bumps the consecutive
//   failure count. MAX_TRIES consecutive failures start a timed lockout.
//
// Ports
//   CLK        in   1  clock, rising edge
//   RST        in   1  asynchronous active-high reset
//   KEY        in   4  code to try
//   KEY_VALID  in   1  one-cycle strobe qualifying KEY
//   CLEAR      in   1  abort entry / relock
//   OPEN_IN    in   1  checker OPEN
//   CORR1_IN   in   1  checker CORR1
//   CORR2_IN   in   1  checker CORR2
//   CODE       out  4  code presented to the checker (registered)
//   UNLOCK     out  1  high for OPEN_CYCLES after a pass
//   FAIL       out  1  one-cycle pulse per failed attempt
//   LOCKED     out  1  high during lockout
//   BUSY       out  1  high whenever not idle
//   STATUS     out  2  {CORR2_IN,CORR1_IN} latched at the last evaluation
//   TRIES      out  2  consecutive failures so far
module code_entry_ctrl #(
    parameter int unsigned SETTLE_CYCLES  = 2,
    parameter int unsigned OPEN_CYCLES    = 8,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] KEY,
    input  logic       KEY_VALID,
    input  logic       CLEAR,
    input  logic       OPEN_IN,
    input  logic       CORR1_IN,
    input  logic       CORR2_IN,
    output logic [3:0] CODE,
    output logic       UNLOCK,
    output logic       FAIL,
    output logic       LOCKED,
    output logic       BUSY,
    output logic [1:0] STATUS,
    output logic [1:0] TRIES
);

    // One shared down-counter serves the settle, open and lockout windows.
    localparam int unsigned TMAX01 = (SETTLE_CYCLES > OPEN_CYCLES) ? SETTLE_CYCLES : OPEN_CYCLES;
    localparam int unsigned TMAX   = (TMAX01 > LOCKOUT_CYCLES) ? TMAX01 : LOCKOUT_CYCLES;
    localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        EVAL,
        UNLOCKED,
        LOCKOUT
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      code_q, code_d;
    logic [1:0]      status_q, status_d;
    logic [1:0]      tries_q, tries_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            fail_q, fail_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            code_q   <= '0;
            status_q <= '0;
            tries_q  <= '0;
            timer_q  <= '0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            status_q <= status_d;
            tries_q  <= tries_d;
            timer_q  <= timer_d;
            fail_q   <= fail_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        status_d = status_q;
        tries_d  = tries_q;
        timer_d  = timer_q;
        fail_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // CLEAR outranks a simultaneous KEY_VALID; the key is dropped.
                if (CLEAR) begin
                    code_d = '0;
                end else if (KEY_VALID) begin
                    code_d  = KEY;
                    timer_d = TW'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (CLEAR) begin
                    code_d  = '0;
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d = EVAL;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            EVAL: begin
                status_d = {CORR2_IN, CORR1_IN};
                if (OPEN_IN) begin
                    tries_d = '0;
                    timer_d = TW'(OPEN_CYCLES - 1);
                    state_d = UNLOCKED;
                end else begin
                    fail_d = 1'b1;
                    if (({1'b0, tries_q} + 3'd1) == 3'(MAX_TRIES)) begin
                        tries_d = '0;
                        timer_d = TW'(LOCKOUT_CYCLES - 1);
                        state_d = LOCKOUT;
                    end else begin
                        tries_d = tries_q + 2'd1;
                        state_d = IDLE;
                    end
                end
            end
            UNLOCKED: begin
                if (CLEAR || (timer_q == '0)) begin
                    code_d  = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    code_d  = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        CODE   = code_q;
        STATUS = status_q;
        TRIES  = tries_q;
        FAIL   = fail_q;
        UNLOCK = (state_q == UNLOCKED);
        LOCKED = (state_q == LOCKOUT);
        BUSY   = (state_q != IDLE);
    end

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Testbench for code_entry_ctrl. The checker is modelled combinationally from
// CODE. The reference model tracks absolute edge numbers: when the pending
// evaluation happens, and which edge ranges have UNLOCK or LOCKED high.
module tb_code_entry_ctrl;

    localparam int unsigned S = 2;
    localparam int unsigned O = 8;
    localparam int unsigned M = 3;
    localparam int unsigned L = 16;

    logic       CLK;
    logic       RST;
    logic [3:0] KEY;
    logic       KEY_VALID;
    logic       CLEAR;
    logic       OPEN_IN;
    logic       CORR1_IN;
    logic       CORR2_IN;
    logic [3:0] CODE;
    logic       UNLOCK;
    logic       FAIL;
    logic       LOCKED;
    logic       BUSY;
    logic [1:0] STATUS;
    logic [1:0] TRIES;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model
    bit         m_pend;
    int         m_eval;
    int         m_ulo, m_uhi, m_llo, m_lhi, m_fail;
    logic [3:0] m_code;
    logic [1:0] m_status;
    int         m_tries;
    bit         e_unlock, e_locked, e_fail, e_busy;

    code_entry_ctrl #(
        .SETTLE_CYCLES (S),
        .OPEN_CYCLES   (O),
        .MAX_TRIES     (M),
        .LOCKOUT_CYCLES(L)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .KEY      (KEY),
        .KEY_VALID(KEY_VALID),
        .CLEAR    (CLEAR),
        .OPEN_IN  (OPEN_IN),
        .CORR1_IN (CORR1_IN),
        .CORR2_IN (CORR2_IN),
        .CODE     (CODE),
        .UNLOCK   (UNLOCK),
        .FAIL     (FAIL),
        .LOCKED   (LOCKED),
        .BUSY     (BUSY),
        .STATUS   (STATUS),
        .TRIES    (TRIES)
    );

    assign OPEN_IN  = (CODE == 4'b1111);
    assign CORR1_IN = CODE[0];
    assign CORR2_IN = CODE[3];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_pend   = 1'b0;
        m_eval   = -100;
        m_ulo    = -100;
        m_uhi    = -101;
        m_llo    = -100;
        m_lhi    = -101;
        m_fail   = -100;
        m_code   = 4'h0;
        m_status = 2'b00;
        m_tries  = 0;
        e_unlock = 1'b0;
        e_locked = 1'b0;
        e_fail   = 1'b0;
        e_busy   = 1'b0;
    endtask

    // Advance the model across edge n, given the inputs sampled at that edge.
    task automatic model_edge(input int n, input logic kv, input logic [3:0] key, input logic clr);
        bit was_unlocked;
        bit was_locked;
        was_unlocked = (n - 1 >= m_ulo) && (n - 1 <= m_uhi);
        was_locked   = (n - 1 >= m_llo) && (n - 1 <= m_lhi);
        if (m_pend && n < m_eval) begin
            if (clr) begin
                m_code = 4'h0;
                m_pend = 1'b0;
            end
        end else if (m_pend && n == m_eval) begin
            m_pend   = 1'b0;
            m_status = {m_code[3], m_code[0]};
            if (m_code == 4'hF) begin
                m_tries = 0;
                m_ulo   = n;
                m_uhi   = n + O - 1;
            end else begin
                m_fail = n;
                if (m_tries + 1 == M) begin
                    m_tries = 0;
                    m_llo   = n;
                    m_lhi   = n + L - 1;
                end else begin
                    m_tries++;
                end
            end
        end else if (was_unlocked) begin
            if (clr || n - 1 == m_uhi) begin
                m_code = 4'h0;
                m_uhi  = n - 1;
            end
        end else if (was_locked) begin
            if (n - 1 == m_lhi) m_code = 4'h0;
        end else begin
            if (clr) begin
                m_code = 4'h0;
            end else if (kv) begin
                m_code = key;
                m_pend = 1'b1;
                m_eval = n + S + 1;
            end
        end
        e_unlock = (n >= m_ulo) && (n <= m_uhi);
        e_locked = (n >= m_llo) && (n <= m_lhi);
        e_fail   = (n == m_fail);
        e_busy   = m_pend || e_unlock || e_locked;
    endtask

    // One clock edge: inputs are taken as currently driven, outputs are
    // observed 1 time unit after the edge, then the strobes are dropped.
    task automatic tick();
        logic       kv;
        logic       c;
        logic [3:0] k;
        kv = KEY_VALID;
        c  = CLEAR;
        k  = KEY;
        @(posedge CLK);
        #1;
        cyc++;
        model_edge(cyc, kv, k, c);
        KEY_VALID = 1'b0;
        CLEAR     = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] k);
        KEY       = k;
        KEY_VALID = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({CODE, UNLOCK, FAIL, LOCKED, BUSY, STATUS, TRIES} !== 12'h000) begin
            errors++;
            $display("FAIL reset_initial: got code=%h u=%b f=%b l=%b b=%b st=%b tr=%0d, want all zero",
                     CODE, UNLOCK, FAIL, LOCKED, BUSY, STATUS, TRIES);
        end
        @(negedge CLK);
        RST = 1'b0;
        strobe(4'hA);
        tick();
        checks++;
        if (CODE !== 4'hA || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_settle: got code=%h busy=%b, want code=a busy=1", CODE, BUSY);
        end
        tick();
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({CODE, UNLOCK, FAIL, LOCKED, BUSY, STATUS, TRIES} !== 12'h000) begin
            errors++;
            $display("FAIL reset_async: got code=%h u=%b f=%b l=%b b=%b st=%b tr=%0d, want all zero",
                     CODE, UNLOCK, FAIL, LOCKED, BUSY, STATUS, TRIES);
        end
        model_reset();
        #2;
        RST = 1'b0;
    endtask

    task automatic test_pass();
        int hi;
        strobe(4'hF);
        tick();
        tick();
        tick();
        checks++;
        if (UNLOCK !== 1'b0) begin
            errors++;
            $display("FAIL pass_early: got unlock=%b after edge 2, want 0", UNLOCK);
        end
        tick();
        checks++;
        if (UNLOCK !== 1'b1 || STATUS !== 2'b11 || TRIES !== 2'd0 || FAIL !== 1'b0) begin
            errors++;
            $display("FAIL pass_open: got u=%b st=%b tr=%0d f=%b, want u=1 st=11 tr=0 f=0",
                     UNLOCK, STATUS, TRIES, FAIL);
        end
        hi = 1;
        for (int i = 0; i < 40 && UNLOCK === 1'b1; i++) begin
            tick();
            if (UNLOCK === 1'b1) hi++;
        end
        checks++;
        if (hi != O) begin
            errors++;
            $display("FAIL pass_width: got unlock high %0d cycles, want %0d", hi, O);
        end
        checks++;
        if (CODE !== 4'h0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL pass_end: got code=%h busy=%b, want code=0 busy=0", CODE, BUSY);
        end
    endtask

    task automatic test_fail();
        strobe(4'h1);
        tick();
        tick();
        tick();
        checks++;
        if (FAIL !== 1'b0) begin
            errors++;
            $display("FAIL fail_early: got fail=%b after edge 2, want 0", FAIL);
        end
        tick();
        checks++;
        if (FAIL !== 1'b1 || STATUS !== 2'b01 || TRIES !== 2'd1 || CODE !== 4'h1 || UNLOCK !== 1'b0) begin
            errors++;
            $display("FAIL fail_pulse: got f=%b st=%b tr=%0d code=%h u=%b, want f=1 st=01 tr=1 code=1 u=0",
                     FAIL, STATUS, TRIES, CODE, UNLOCK);
        end
        tick();
        checks++;
        if (FAIL !== 1'b0 || CODE !== 4'h1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL fail_after: got f=%b code=%h busy=%b, want f=0 code=1 busy=0", FAIL, CODE, BUSY);
        end
    endtask

    task automatic test_lockout();
        int  lk;
        bit  bad_code;
        bit  saw_unlock;
        strobe(4'h2);
        repeat (4) tick();
        checks++;
        if (FAIL !== 1'b1 || TRIES !== 2'd2 || LOCKED !== 1'b0) begin
            errors++;
            $display("FAIL lock_second: got f=%b tr=%0d l=%b, want f=1 tr=2 l=0", FAIL, TRIES, LOCKED);
        end
        tick();
        strobe(4'h4);
        repeat (4) tick();
        checks++;
        if (FAIL !== 1'b1 || LOCKED !== 1'b1 || TRIES !== 2'd0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL lock_enter: got f=%b l=%b tr=%0d b=%b, want f=1 l=1 tr=0 b=1",
                     FAIL, LOCKED, TRIES, BUSY);
        end
        lk         = 1;
        bad_code   = 1'b0;
        saw_unlock = 1'b0;
        for (int i = 0; i < 60 && LOCKED === 1'b1; i++) begin
            if (i == 2) strobe(4'hF);
            if (i == 5) CLEAR = 1'b1;
            tick();
            if (LOCKED === 1'b1) begin
                lk++;
                if (CODE !== 4'h4) bad_code = 1'b1;
            end
            if (UNLOCK === 1'b1) saw_unlock = 1'b1;
        end
        checks++;
        if (lk != L) begin
            errors++;
            $display("FAIL lock_width: got locked high %0d cycles, want %0d", lk, L);
        end
        checks++;
        if (bad_code || saw_unlock) begin
            errors++;
            $display("FAIL lock_ignore: got code_changed=%b unlock_seen=%b, want 0 0", bad_code, saw_unlock);
        end
        checks++;
        if (CODE !== 4'h0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL lock_end: got code=%h busy=%b, want code=0 busy=0", CODE, BUSY);
        end
        repeat (5) tick();
        checks++;
        if (UNLOCK !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL lock_noqueue: got u=%b b=%b, want 0 0", UNLOCK, BUSY);
        end
    endtask

    task automatic test_clear();
        strobe(4'h5);
        CLEAR = 1'b1;
        tick();
        checks++;
        if (CODE !== 4'h0 || BUSY !== 1'b0 || TRIES !== 2'd0) begin
            errors++;
            $display("FAIL clear_collision: got code=%h b=%b tr=%0d, want code=0 b=0 tr=0", CODE, BUSY, TRIES);
        end
        repeat (4) tick();
        checks++;
        if (FAIL !== 1'b0 || TRIES !== 2'd0) begin
            errors++;
            $display("FAIL clear_noattempt: got f=%b tr=%0d, want f=0 tr=0", FAIL, TRIES);
        end
        strobe(4'hF);
        tick();
        CLEAR = 1'b1;
        tick();
        checks++;
        if (CODE !== 4'h0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL clear_settle: got code=%h b=%b, want code=0 b=0", CODE, BUSY);
        end
        repeat (3) tick();
        checks++;
        if (UNLOCK !== 1'b0 || FAIL !== 1'b0) begin
            errors++;
            $display("FAIL clear_settle_after: got u=%b f=%b, want 0 0", UNLOCK, FAIL);
        end
        strobe(4'hF);
        repeat (4) tick();
        tick();
        checks++;
        if (UNLOCK !== 1'b1) begin
            errors++;
            $display("FAIL clear_unlock_pre: got unlock=%b, want 1", UNLOCK);
        end
        CLEAR = 1'b1;
        tick();
        checks++;
        if (UNLOCK !== 1'b0 || CODE !== 4'h0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL clear_unlock: got u=%b code=%h b=%b, want u=0 code=0 b=0", UNLOCK, CODE, BUSY);
        end
    endtask

    task automatic test_busy_ignore();
        strobe(4'h2);
        tick();
        strobe(4'hF);
        tick();
        tick();
        tick();
        checks++;
        if (FAIL !== 1'b1 || UNLOCK !== 1'b0 || CODE !== 4'h2 || TRIES !== 2'd1) begin
            errors++;
            $display("FAIL busy_ignore: got f=%b u=%b code=%h tr=%0d, want f=1 u=0 code=2 tr=1",
                     FAIL, UNLOCK, CODE, TRIES);
        end
        repeat (4) tick();
        checks++;
        if (UNLOCK !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignore_after: got u=%b b=%b, want 0 0", UNLOCK, BUSY);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            KEY_VALID = ($urandom_range(0, 3) == 0);
            KEY       = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            CLEAR     = ($urandom_range(0, 19) == 0);
            tick();
            checks++;
            if (CODE !== m_code) begin
                errors++;
                $display("FAIL rnd_code @%0d: got %h want %h", cyc, CODE, m_code);
            end
            checks++;
            if (UNLOCK !== e_unlock) begin
                errors++;
                $display("FAIL rnd_unlock @%0d: got %b want %b", cyc, UNLOCK, e_unlock);
            end
            checks++;
            if (FAIL !== e_fail) begin
                errors++;
                $display("FAIL rnd_fail @%0d: got %b want %b", cyc, FAIL, e_fail);
            end
            checks++;
            if (LOCKED !== e_locked) begin
                errors++;
                $display("FAIL rnd_locked @%0d: got %b want %b", cyc, LOCKED, e_locked);
            end
            checks++;
            if (BUSY !== e_busy) begin
                errors++;
                $display("FAIL rnd_busy @%0d: got %b want %b", cyc, BUSY, e_busy);
            end
            checks++;
            if (STATUS !== m_status) begin
                errors++;
                $display("FAIL rnd_status @%0d: got %b want %b", cyc, STATUS, m_status);
            end
            checks++;
            if (TRIES !== 2'(m_tries)) begin
                errors++;
                $display("FAIL rnd_tries @%0d: got %0d want %0d", cyc, TRIES, m_tries);
            end
        end
    endtask

    initial begin
        RST       = 1'b1;
        KEY       = 4'h0;
        KEY_VALID = 1'b0;
        CLEAR     = 1'b0;
        model_reset();
        test_reset();
        test_pass();
        test_fail();
        test_lockout();
        test_clear();
        test_busy_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
